// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one outstanding access, byte-lane strobes, extended load data.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,  resp_err_d;
    logic [2:0]        f3_q,        f3_d;
    logic [1:0]        lsb_q,       lsb_d;

    logic              req_legal;
    logic              req_misalign;
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    // Request decode: legality, alignment and store lane placement
    always_comb begin
        req_legal    = 1'b0;
        req_misalign = 1'b0;
        st_strb      = 4'b0000;
        st_data      = '0;

        if (req_write) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end

`ifdef LSU_MISALIGN_CHECK_EN
        req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_misalign = 1'b0;
`endif

        if (req_write) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_strb = 4'b0001 << req_addr[1:0];
                    st_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_strb = 4'b1111;
                    st_data = req_wdata;
                end
            endcase
        end
    end

    // Load lane select and extension, using the captured funct3 and address LSBs
    always_comb begin
        ld_byte = 8'h00;
        ld_half = lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext  = '0;

        case (lsb_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase

        case (f3_q)
            3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        f3_d         = f3_q;
        lsb_d        = lsb_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    lsb_d = req_addr[1:0];
                    if (!req_legal || req_misalign) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = S_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = st_strb;
                        mem_wdata_d = st_data;
                    end
                end
            end
            S_BUS: begin
                if (mem_ack) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? '0 : ld_ext;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            f3_q         <= '0;
            lsb_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            f3_q         <= f3_d;
            lsb_q        <= lsb_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUS);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
